// File: rtl/sm_accum4_pkg.sv
// ----------------------------------------------------------------------------
// sm_accum_pkg
// Shared types and constants for the 4-bit sign-magnitude accumulator.
//   sm_num_t   : packed sign-magnitude number (sign 1 = negative, 4-bit mag)
//   state_t    : accumulator control states
//   SM_MAG_MAX : largest representable magnitude (saturation value)
//   SM_ZERO    : canonical zero (+0)
//   sm_norm()  : forces the sign of any zero magnitude to 0
// ----------------------------------------------------------------------------
package sm_accum_pkg;

    typedef struct packed {
        logic       sign;
        logic [3:0] mag;
    } sm_num_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SM_MAG_MAX = 4'hF;
    localparam sm_num_t    SM_ZERO    = '{sign: 1'b0, mag: 4'h0};

    // -0 and +0 are the same value; only +0 is ever stored or presented.
    function automatic sm_num_t sm_norm(input sm_num_t x);
        sm_num_t r;
        r = x;
        if (x.mag == 4'h0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_accum4_if.sv
// ----------------------------------------------------------------------------
// sm_accum4_if
// Sample-in / result-out handshake bundle of sm_accum4.
//   in_valid, in_mag, in_sign, in_ready      : sample stream
//   out_valid, out_mag, out_sign, out_ovf,
//   out_ready                                : result stream
// Modports:
//   master : the environment (produces samples, consumes results)
//   slave  : the accumulator
// ----------------------------------------------------------------------------
interface sm_accum4_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_mag;
    logic       in_sign;

    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_mag;
    logic       out_sign;
    logic       out_ovf;

    modport master (
        output in_valid, in_mag, in_sign, out_ready,
        input  in_ready, out_valid, out_mag, out_sign, out_ovf
    );

    modport slave (
        input  in_valid, in_mag, in_sign, out_ready,
        output in_ready, out_valid, out_mag, out_sign, out_ovf
    );

endinterface

// File: rtl/sm_accum4_add_core.sv
// ----------------------------------------------------------------------------
// sm_add_core
// Purely combinational 4-bit sign-magnitude adder with saturation.
//   a, b : operands (sm_num_t); -0 is accepted and treated as +0
//   sum  : exact sign-magnitude sum, saturated to magnitude 4'hF on overflow,
//          zero always returned as +0
//   sat  : 1 when the magnitude overflowed and was clamped
// ----------------------------------------------------------------------------
module sm_add_core
    import sm_accum_pkg::*;
(
    input  sm_num_t a,
    input  sm_num_t b,
    output sm_num_t sum,
    output logic    sat
);

    sm_num_t    a_n;
    sm_num_t    b_n;
    logic [4:0] mag_sum;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, otherwise an untaken path infers a latch.
        sum     = SM_ZERO;
        sat     = 1'b0;
        a_n     = sm_norm(a);
        b_n     = sm_norm(b);
        mag_sum = {1'b0, a_n.mag} + {1'b0, b_n.mag};

        if (a_n.sign == b_n.sign) begin
            // Same sign: magnitudes add; a carry out of bit 3 clamps.
            sum.sign = a_n.sign;
            if (mag_sum[4]) begin
                sum.mag = SM_MAG_MAX;
                sat     = 1'b1;
            end else begin
                sum.mag = mag_sum[3:0];
            end
        end else if (a_n.mag >= b_n.mag) begin
            // Opposite signs: larger magnitude wins, never overflows.
            sum.sign = a_n.sign;
            sum.mag  = a_n.mag - b_n.mag;
        end else begin
            sum.sign = b_n.sign;
            sum.mag  = b_n.mag - a_n.mag;
        end

        // Equal magnitudes with opposite signs land here as -0 or +0.
        sum = sm_norm(sum);
    end

endmodule

// File: rtl/sm_accum4.sv
// ----------------------------------------------------------------------------
// sm_accum4
// Sequential sign-magnitude accumulator. After a start pulse it folds
// N_SAMPLES sign-magnitude samples into a registered total through
// sm_add_core, then holds the saturated total and a sticky overflow flag
// until the consumer takes it.
//
// Parameters:
//   N_SAMPLES : samples per run (1..255)
//   CNT_W     : sample counter width (derived)
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle run request, honoured only in IDLE
//   abort      : (SM_ACC_ABORT_EN only) cancel a run in ACCUM
//   bus        : sm_accum4_if.slave sample/result handshake
//   busy       : high in ACCUM or DONE
//   sample_cnt : samples accepted so far in the current run
//
// Build option: define SM_ACC_ABORT_EN to add the abort port.
// ----------------------------------------------------------------------------
module sm_accum4
    import sm_accum_pkg::*;
#(
    parameter  int N_SAMPLES = 8,
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SM_ACC_ABORT_EN
    input  logic             abort,
`endif
    sm_accum4_if.slave       bus,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t           state_q;
    state_t           state_d;
    sm_num_t          acc_q;
    sm_num_t          sample;
    sm_num_t          add_sum;
    logic             add_sat;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             abort_req;
    logic             xfer;
    logic             clear;

`ifdef SM_ACC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign sample = '{sign: bus.in_sign, mag: bus.in_mag};

    sm_add_core u_add (
        .a   (acc_q),
        .b   (sample),
        .sum (add_sum),
        .sat (add_sat)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshake outputs and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        xfer          = 1'b0;
        clear         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                // Abort beats a same-cycle transfer; that sample is dropped.
                if (abort_req) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    xfer = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, sticky overflow and sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= SM_ZERO;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= SM_ZERO;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (xfer) begin
            acc_q <= add_sum;
            ovf_q <= ovf_q | add_sat;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Results are registered and only change on a transfer, so they stay
    // stable for the whole DONE phase.
    assign bus.out_mag  = acc_q.mag;
    assign bus.out_sign = acc_q.sign;
    assign bus.out_ovf  = ovf_q;
    assign sample_cnt   = cnt_q;

endmodule
